// File: rtl/anton_neopixel_bus_arbiter_pkg.sv
// Shared types and defaults for the NeoPixel bus arbiter.
package anton_neopixel_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

  localparam int unsigned LOCK_MAX_DEFAULT = 16;

endpackage

// File: rtl/anton_rr_pick2.sv
// Combinational 2-way round-robin pick: on contention the requester that
// was not granted last wins.
module anton_rr_pick2
  import anton_neopixel_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  // Pick the lone requester, or the one that is not 'last' when both ask
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last;
    end else begin
      grant_idx = req1;
    end
  end

endmodule

// File: rtl/anton_neopixel_bus_arbiter.sv
// Two-requester round-robin arbiter for the byte-wide NeoPixel core bus,
// with bounded burst lock and registered read-data return.
module anton_neopixel_bus_arbiter
  import anton_neopixel_bus_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic        busClk,
  input  logic        busResetn,
  input  logic        m0Req,
  input  logic        m0Write,
  input  logic [13:0] m0Addr,
  input  logic [7:0]  m0Wdata,
  input  logic        m0Lock,
  output logic        m0Ack,
  output logic [7:0]  m0Rdata,
  input  logic        m1Req,
  input  logic        m1Write,
  input  logic [13:0] m1Addr,
  input  logic [7:0]  m1Wdata,
  input  logic        m1Lock,
  output logic        m1Ack,
  output logic [7:0]  m1Rdata,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut,
  output logic        busOwner
);

  localparam int unsigned LOCK_BITS = $clog2(LOCK_MAX + 1);
  localparam logic [LOCK_BITS-1:0] LOCK_LAST = LOCK_BITS'(LOCK_MAX - 1);

  arb_state_e           state, state_next;
  logic [LOCK_BITS-1:0] lock_cnt, cnt_next;
  logic                 dir;
  logic                 load, load_idx;
  logic                 pick_valid, pick_idx;
  logic                 own_req, own_lock, other_req;

  anton_rr_pick2 u_pick (
    .req0        (m0Req),
    .req1        (m1Req),
    .last        (busOwner),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  assign own_req   = busOwner ? m1Req  : m0Req;
  assign own_lock  = busOwner ? m1Lock : m0Lock;
  assign other_req = busOwner ? m0Req  : m1Req;

  assign busWrite = (state == ARB_ISSUE) &&  dir;
  assign busRead  = (state == ARB_ISSUE) && !dir;
  assign m0Ack    = (state == ARB_ACK) && !busOwner;
  assign m1Ack    = (state == ARB_ACK) &&  busOwner;

  // State register
  always_ff @(posedge busClk) begin
    if (!busResetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, grant/latch decision and lock-counter update
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_idx   = busOwner;
    cnt_next   = lock_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          load       = 1'b1;
          load_idx   = pick_idx;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_next = ARB_WAIT;
      ARB_WAIT:  state_next = ARB_ACK;
      ARB_ACK: begin
        // Lock continuation is refused only when the budget is spent AND the
        // other side is waiting; unopposed, the counter just saturates.
        if (own_lock && own_req && !((lock_cnt == LOCK_LAST) && other_req)) begin
          load       = 1'b1;
          load_idx   = busOwner;
          state_next = ARB_ISSUE;
          if (lock_cnt != LOCK_LAST) begin
            cnt_next = lock_cnt + LOCK_BITS'(1);
          end
        end else begin
          cnt_next   = '0;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grant latching, owner tracking and read-data capture
  always_ff @(posedge busClk) begin
    if (!busResetn) begin
      busAddr   <= '0;
      busDataIn <= '0;
      dir       <= 1'b0;
      busOwner  <= 1'b1;
      lock_cnt  <= '0;
      m0Rdata   <= '0;
      m1Rdata   <= '0;
    end else begin
      lock_cnt <= cnt_next;
      if (load) begin
        busOwner  <= load_idx;
        busAddr   <= load_idx ? m1Addr  : m0Addr;
        busDataIn <= load_idx ? m1Wdata : m0Wdata;
        dir       <= load_idx ? m1Write : m0Write;
      end
      if ((state == ARB_WAIT) && !dir) begin
        if (busOwner) begin
          m1Rdata <= busDataOut;
        end else begin
          m0Rdata <= busDataOut;
        end
      end
    end
  end

endmodule

// File: doc/anton_neopixel_bus_arbiter.md
Name: anton_neopixel_bus_arbiter

Overview:
- Shares the single byte-wide pixel/register bus of the raw NeoPixel core between two requesters.
- Requester 0 is the CPU/APB bridge. Requester 1 is the animation/pattern engine.
- Round-robin arbitration with optional bounded burst lock, one transaction in flight, registered read-data return.
- Sits between the requesters and the core's busAddr/busDataIn/busWrite/busRead/busDataOut port, all on busClk.

Parameters:
- LOCK_MAX, 16: max consecutive locked transactions before forced re-arbitration when the other requester is pending (1..255).
- LOCK_BITS, `CLOG2(LOCK_MAX+1): lock counter width (localparam).

Ports:
- busClk  in  1  bus clock; all logic on its posedge.
- busResetn  in  1  synchronous, active-low reset.
- m0Req  in  1  requester 0 transaction request; held until m0Ack.
- m0Write  in  1  1=write, 0=read; stable while m0Req.
- m0Addr  in  14  byte address (bit 13 selects control registers); stable while m0Req.
- m0Wdata  in  8  write data; stable while m0Req.
- m0Lock  in  1  keep grant for the next transaction.
- m0Ack  out  1  one-cycle completion pulse.
- m0Rdata  out  8  read data, valid while m0Ack=1.
- m1Req, m1Write, m1Addr[13:0], m1Wdata[7:0], m1Lock, m1Ack, m1Rdata[7:0]: same as the m0 ports, for requester 1.
- busAddr  out  14  address to core.
- busDataIn  out  8  write data to core.
- busWrite  out  1  one-cycle write strobe.
- busRead  out  1  one-cycle read strobe.
- busDataOut  in  8  core read data, registered by the core one edge after busRead.
- busOwner  out  1  index of the current or last granted requester.

Behaviour:
- Reset (busResetn=0 at posedge):
  - state=IDLE; all outputs 0; busOwner=1, so requester 0 wins the first contention.
  - lock counter 0; any in-flight transaction is abandoned with no ack.
- States: IDLE -> ISSUE -> WAIT -> ACK -> (IDLE | ISSUE).
- IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant the requester != busOwner.
  - On grant, latch addr/wdata/write into busAddr/busDataIn and an internal dir flag, set busOwner, go to ISSUE.
- ISSUE (1 cycle):
  - busWrite=dir or busRead=!dir; exactly one strobe high, for exactly this cycle.
  - Go to WAIT.
- WAIT (1 cycle):
  - No strobe. busDataOut is valid from the core.
  - Capture busDataOut into the owner's rdata register; writes capture nothing and rdata holds its old value.
  - Go to ACK.
- ACK (1 cycle):
  - Owner's ack=1 and its rdata is valid; the other requester's ack=0.
  - busAddr/busDataIn hold their values until the next grant.
- Latency: req seen in IDLE at cycle t -> strobe at t+1 -> ack at t+3. A granted requester completes one transaction per 4 cycles; a lock continuation takes 3 cycles.
- Lock, evaluated in ACK using the owner's current req/lock/fields (the next transaction):
  - If owner lock=1, owner req=1, and NOT (lock counter==LOCK_MAX-1 and other req=1): latch the new fields, counter+1, go directly to ISSUE.
  - Otherwise: counter=0, go to IDLE, where normal round-robin applies.
  - An unopposed lock never expires: the counter saturates at LOCK_MAX-1 and does not wrap.
- Requester protocol:
  - Req and fields are sampled only at grant; later changes are ignored until ack.
  - Req dropped before ack: the transaction still completes and ack still pulses.
  - Req held high after ack starts a new transaction.
- Both acks are never high in the same cycle; busWrite and busRead are never high together.
- No address decode. All 14 bits pass through unchanged; core register semantics (reg_ctrl_init self-clear, etc.) are untouched.

Decomposition:
- Shared include anton_common.vh: add arbiter state encodings (ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_ACK=2'd3) and LOCK_MAX_DEFAULT=16; `CLOG2 is reused.
- One sub-module is natural: anton_rr_pick2. It is a combinational 2-way round-robin pick from (req0, req1, last) to (grant_valid, grant_idx); the arbiter FSM, lock counter, and muxes remain in the top.

Test Plan:
- Reset with m0Req=1 held low-reset 3 cycles, release -> busWrite/busRead stay 0 during reset; first strobe 1 cycle after release with m0's address; busOwner=0.
- m0 write addr 0x2000 data 0xA5 -> busWrite=1 for exactly 1 cycle with busAddr=0x2000, busDataIn=0xA5; m0Ack at strobe+2; m1Ack stays 0.
- m1 read addr 0x0005, core returns 0x3C -> busRead single cycle; m1Ack pulse with m1Rdata=0x3C; m0Rdata unchanged.
- m0Req and m1Req both held continuously, no lock -> grants alternate m0,m1,m0,m1; each ack 4 cycles apart.
- m1Lock=1 with m1Req held, m0Req asserted, LOCK_MAX=4 -> exactly 4 consecutive m1 transactions, 3 cycles apart; next grant is m0; counter restarts.
- Reset asserted during WAIT of an m0 read -> no m0Ack; outputs 0 next cycle; a fresh m1 request after release completes normally.
